// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline freeze/flush sequencer.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned REG_W_DEF        = 5;
  localparam int unsigned MEM_WAIT_MAX_DEF = 15;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned REG_ZERO         = 0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // One-bit pipeline controls produced each cycle.
  typedef struct packed {
    logic freeze_if;
    logic freeze_id;
    logic flush_id;
    logic bubble_exe;
    logic freeze_pipe;
    logic mem_timeout;
  } ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory status from the pipe and the stall controls returned to it.
interface pipeline_stall_ctrl_if
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_src_valid;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             fwd_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             freeze_if;
  logic             freeze_id;
  logic             flush_id;
  logic             bubble_exe;
  logic             freeze_pipe;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: reports stage state, consumes stall controls.
  modport master (
    output id_src1, id_src2, id_two_src, id_src_valid,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           fwd_en, branch_taken, mem_req, mem_ready,
    input  freeze_if, freeze_id, flush_id, bubble_exe, freeze_pipe,
           mem_timeout, stall_cnt
  );

  // Controller side.
  modport slave (
    input  id_src1, id_src2, id_two_src, id_src_valid,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           fwd_en, branch_taken, mem_req, mem_ready,
    output freeze_if, freeze_id, flush_id, bubble_exe, freeze_pipe,
           mem_timeout, stall_cnt
  );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational RAW hazard check of the ID operands against EXE/MEM writers.
module pipeline_stall_ctrl_hazard_detect
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_two_src_i,
  input  logic             id_src_valid_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             fwd_en_i,
  output logic             raw_o
);

  logic exe_hit_c;
  logic mem_hit_c;

  // Register zero is never a real dependency; src2 only counts when it is read.
  always_comb begin
    exe_hit_c = exe_wb_en_i && (exe_dest_i != REG_W'(REG_ZERO)) &&
                ((exe_dest_i == id_src1_i) || (id_two_src_i && (exe_dest_i == id_src2_i)));
    mem_hit_c = mem_wb_en_i && (mem_dest_i != REG_W'(REG_ZERO)) &&
                ((mem_dest_i == id_src1_i) || (id_two_src_i && (mem_dest_i == id_src2_i)));
    // With forwarding only a load feeding the next instruction must stall.
    if (fwd_en_i) begin
      raw_o = id_src_valid_i && exe_mem_r_en_i && exe_hit_c;
    end else begin
      raw_o = id_src_valid_i && (exe_hit_c || mem_hit_c);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Freeze/flush sequencer: RAW stalls, branch flushes and data-memory wait holds.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);

  localparam int unsigned    WAIT_W  = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  ctrl_t             ctrl_c;
  logic              raw_c;

  pipeline_stall_ctrl_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .id_src1_i      (bus.id_src1),
    .id_src2_i      (bus.id_src2),
    .id_two_src_i   (bus.id_two_src),
    .id_src_valid_i (bus.id_src_valid),
    .exe_dest_i     (bus.exe_dest),
    .exe_wb_en_i    (bus.exe_wb_en),
    .exe_mem_r_en_i (bus.exe_mem_r_en),
    .mem_dest_i     (bus.mem_dest),
    .mem_wb_en_i    (bus.mem_wb_en),
    .fwd_en_i       (bus.fwd_en),
    .raw_o          (raw_c)
  );

  // State, wait counter and stall statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state and same-cycle Mealy controls.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl_c  = '0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          ctrl_c.freeze_pipe = 1'b1;
          state_d            = ST_MEM_WAIT;
          wait_d             = WAIT_W'(1);
        end else if (bus.branch_taken) begin
          ctrl_c.flush_id   = 1'b1;
          ctrl_c.bubble_exe = 1'b1;
        end else if (raw_c) begin
          ctrl_c.freeze_if  = 1'b1;
          ctrl_c.freeze_id  = 1'b1;
          ctrl_c.bubble_exe = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Branch and hazard requests are deliberately ignored until release.
        ctrl_c.freeze_pipe = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_WAIT_MAX)) begin
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        ctrl_c.freeze_pipe = 1'b1;
        ctrl_c.mem_timeout = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
    if (ctrl_c.freeze_pipe) begin
      ctrl_c.freeze_if = 1'b1;
      ctrl_c.freeze_id = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl_c.freeze_if && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Controls are forced low for the whole time reset is asserted.
  assign bus.freeze_if   = ctrl_c.freeze_if   & ~rst;
  assign bus.freeze_id   = ctrl_c.freeze_id   & ~rst;
  assign bus.flush_id    = ctrl_c.flush_id    & ~rst;
  assign bus.bubble_exe  = ctrl_c.bubble_exe  & ~rst;
  assign bus.freeze_pipe = ctrl_c.freeze_pipe & ~rst;
  assign bus.mem_timeout = ctrl_c.mem_timeout & ~rst;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl with a scoreboard of expected controls.
module tb_pipeline_stall_ctrl;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned MWM     = 15;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .REG_W        (REG_W),
    .MEM_WAIT_MAX (MWM),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0] s1;
    logic [4:0] s2;
    logic       two;
    logic       valid;
    logic [4:0] ed;
    logic       ewb;
    logic       eload;
    logic [4:0] md;
    logic       mwb;
    logic       fwd;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct {
    string            tag;
    logic [5:0]       ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: 0 run, 1 wait, 2 halt.
  int unsigned m_state, m_wcnt, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.freeze_if, bus.freeze_id, bus.flush_id, bus.bubble_exe,
            bus.freeze_pipe, bus.mem_timeout};
  endfunction

  task automatic apply(input stim_t s);
    bus.id_src1      = s.s1;
    bus.id_src2      = s.s2;
    bus.id_two_src   = s.two;
    bus.id_src_valid = s.valid;
    bus.exe_dest     = s.ed;
    bus.exe_wb_en    = s.ewb;
    bus.exe_mem_r_en = s.eload;
    bus.mem_dest     = s.md;
    bus.mem_wb_en    = s.mwb;
    bus.fwd_en       = s.fwd;
    bus.branch_taken = s.br;
    bus.mem_req      = s.mreq;
    bus.mem_ready    = s.mrdy;
  endtask

  function automatic logic hit(input logic [4:0] d, input logic en, input stim_t s);
    return en && (d != 5'd0) && ((d == s.s1) || (s.two && (d == s.s2)));
  endfunction

  // Drive one cycle, predict, compare mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input stim_t s);
    exp_t        e;
    logic        raw, fi, fid, fl, bub, fp, to;
    int unsigned ns, nw;
    apply(s);
    raw = s.valid && (s.fwd ? (s.eload && hit(s.ed, s.ewb, s))
                            : (hit(s.ed, s.ewb, s) || hit(s.md, s.mwb, s)));
    {fi, fid, fl, bub, fp, to} = 6'b0;
    ns = m_state;
    nw = m_wcnt;
    case (m_state)
      0: begin
        if (s.mreq && !s.mrdy) begin fp = 1'b1; ns = 1; nw = 1; end
        else if (s.br) begin fl = 1'b1; bub = 1'b1; end
        else if (raw) begin fi = 1'b1; fid = 1'b1; bub = 1'b1; end
      end
      1: begin
        fp = 1'b1;
        if (s.mrdy) begin ns = 0; nw = 0; end
        else if (m_wcnt == MWM) ns = 2;
        else nw = m_wcnt + 1;
      end
      default: begin fp = 1'b1; to = 1'b1; end
    endcase
    if (fp) begin fi = 1'b1; fid = 1'b1; end
    e.tag  = tag;
    e.ctrl = {fi, fid, fl, bub, fp, to};
    e.cnt  = CNT_W'(m_cnt);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_eq({e.tag, ".ctrl"}, 32'(outs()), 32'(e.ctrl));
    check_eq({e.tag, ".cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
    @(posedge clk);
    m_state = ns;
    m_wcnt  = nw;
    if (fi && (m_cnt < CNT_MAX)) m_cnt++;
    #1;
  endtask

  // Assert reset with the given inputs; controls must drop at once and stay low.
  task automatic do_reset(input string tag, input stim_t s);
    apply(s);
    rst = 1'b1;
    #1;
    check_eq({tag, ".async_ctrl"}, 32'(outs()), 32'd0);
    check_eq({tag, ".async_cnt"}, 32'(bus.stall_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".hold_ctrl"}, 32'(outs()), 32'd0);
    apply('0);
    rst     = 1'b0;
    m_state = 0;
    m_wcnt  = 0;
    m_cnt   = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;

    // Reset while a hazard is presented.
    s = '0; s.valid = 1'b1; s.s1 = 5'd3; s.ed = 5'd3; s.ewb = 1'b1; s.br = 1'b1;
    do_reset("reset", s);
    step("idle", '0);

    // Non-forwarding hazards.
    s = '0; s.valid = 1'b1; s.s1 = 5'd3; s.ed = 5'd3; s.ewb = 1'b1;
    step("exe_raw", s);
    s.ed = 5'd0; s.s1 = 5'd0;
    step("exe_r0", s);
    s = '0; s.valid = 1'b1; s.s1 = 5'd1; s.s2 = 5'd7; s.two = 1'b1; s.md = 5'd7; s.mwb = 1'b1;
    step("mem_raw_src2", s);
    s.two = 1'b0;
    step("mem_src2_unread", s);
    s.two = 1'b1; s.valid = 1'b0;
    step("not_valid", s);
    s.valid = 1'b1; s.mwb = 1'b0;
    step("mem_no_wb", s);

    // Forwarding: only load-use stalls.
    s = '0; s.fwd = 1'b1; s.valid = 1'b1; s.two = 1'b1; s.s2 = 5'd4; s.ed = 5'd4;
    s.ewb = 1'b1; s.eload = 1'b1;
    step("load_use", s);
    s.eload = 1'b0;
    step("fwd_alu", s);
    s = '0; s.fwd = 1'b1; s.valid = 1'b1; s.s1 = 5'd9; s.md = 5'd9; s.mwb = 1'b1;
    step("fwd_mem", s);

    // Branch beats a hazard.
    s = '0; s.valid = 1'b1; s.s1 = 5'd3; s.ed = 5'd3; s.ewb = 1'b1; s.br = 1'b1;
    step("branch_raw", s);

    // Zero-wait memory access.
    s = '0; s.mreq = 1'b1; s.mrdy = 1'b1;
    step("mem_zero_wait", s);

    // Three-cycle wait with a branch mid-wait; four freeze cycles from a clean count.
    do_reset("reset2", '0);
    s = '0; s.mreq = 1'b1;
    step("wait0", s);
    s.br = 1'b1; s.valid = 1'b1; s.s1 = 5'd3; s.ed = 5'd3; s.ewb = 1'b1;
    step("wait1_branch", s);
    s = '0; s.mreq = 1'b1;
    step("wait2", s);
    s.mrdy = 1'b1;
    step("wait_release", s);
    check_eq("wait_stall_total", 32'(bus.stall_cnt), 32'd4);
    step("after_release", '0);

    // Ready in the limit cycle wins over HALT.
    s = '0; s.mreq = 1'b1;
    for (int i = 0; i < 15; i++) step("limit_wait", s);
    s.mrdy = 1'b1;
    step("limit_ready", s);
    check_eq("limit_no_timeout", 32'(bus.mem_timeout), 32'd0);
    step("limit_after", '0);

    // Never ready: HALT after 16 freeze cycles, sticky until reset.
    s = '0; s.mreq = 1'b1;
    for (int i = 0; i < 15; i++) step("halt_wait", s);
    check_eq("halt_not_yet", 32'(bus.mem_timeout), 32'd0);
    step("halt_last", s);
    check_eq("halt_timeout", 32'(bus.mem_timeout), 32'd1);
    s.mrdy = 1'b1;
    step("halt_ready_ignored", s);
    step("halt_idle", '0);
    #1;
    do_reset("reset_halt", '0);
    step("post_halt", '0);

    // Stall counter saturation.
    s = '0; s.valid = 1'b1; s.s1 = 5'd5; s.ed = 5'd5; s.ewb = 1'b1;
    for (int i = 0; i < 70; i++) step("sat", s);
    check_eq("sat_value", 32'(bus.stall_cnt), 32'(CNT_MAX));
    step("sat_idle", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
